writeback_commit_arbiter: RTL

// - Shares one register-file commit port between NUM_UNITS execution-unit writeback ports.
// - Sits between the unit writeback interfaces (wb_packet_t plus phys_addr_t) and the

---
 rtl/cva5_types.sv | 37 +++
 rtl/rr_priority_select.sv | 50 +++++
 rtl/writeback_commit_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cva5_types.sv
// Shared CVA5 type package (slice used by the writeback commit path).
//
// Contents:
//   LOG2_MAX_IDS     width of an instruction ID
//   MAX_WB_UNITS     upper bound on writeback requesters sharing one commit port
//   id_t             instruction ID
//   phys_addr_t      physical register-file address (6 bits)
//   wb_packet_t      per-unit writeback result {id, valid, data}
//   commit_packet_t  register-file commit {id, valid, phys_addr, data}
//   wrap_inc()       modulo-n increment used by round-robin pointers
package cva5_types;

  localparam int LOG2_MAX_IDS = 3;
  localparam int MAX_WB_UNITS = 8;

  typedef logic [LOG2_MAX_IDS-1:0] id_t;
  typedef logic [5:0]              phys_addr_t;

  typedef struct packed {
    id_t         id;
    logic        valid;
    logic [31:0] data;
  } wb_packet_t;

  typedef struct packed {
    id_t         id;
    logic        valid;
    phys_addr_t  phys_addr;
    logic [31:0] data;
  } commit_packet_t;

  // Index after idx in a ring of n entries; n-1 wraps back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin request selector, purely combinational.
//
// Grants the first asserted request at or after ptr, scanning upward and
// wrapping modulo NUM_REQ. Reusable by any arbiter that keeps its own pointer.
//
// Ports:
//   req         in   NUM_REQ  request vector
//   ptr         in   IDX_W    first index to consider (must be < NUM_REQ)
//   grant       out  NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx   out  IDX_W    index of the granted request (0 when none)
//   grant_valid out  1        at least one request was asserted
module rr_priority_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before any conditional assignment, so
    // no path leaves a signal unassigned and no latch is inferred.
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;

    // Scan from the farthest offset down to offset 0; the last hit written is
    // the one closest to ptr, which is the round-robin winner.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req[idx]) begin
        grant_idx   = IDX_W'(idx);
        grant_valid = 1'b1;
      end
    end

    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/writeback_commit_arbiter.sv
// Writeback commit arbiter.
//
// Shares one register-file commit port between NUM_UNITS execution-unit
// writeback ports. Round-robin among units, with an optional fixed-priority
// unit (PRIORITY_UNIT >= 0) whose results cannot stall. The grant is
// combinational (wb_ack); the granted result is registered onto commit one
// cycle later. The commit port never back-pressures.
//
// Parameters:
//   NUM_UNITS      number of writeback requesters, 2..MAX_WB_UNITS
//   PRIORITY_UNIT  unit that always wins when valid; -1 = pure round-robin
//
// Ports:
//   clk                in   1               rising-edge clock
//   rst                in   1               asynchronous reset, active-low
//   wb_packet          in   NUM_UNITS x wb_packet_t  per-unit {id, valid, data}
//   wb_phys_addr       in   NUM_UNITS x phys_addr_t  per-unit destination
//   wb_ack             out  NUM_UNITS       one-hot grant; unit drops its result
//   writeback_supress  in   1               block all grants this cycle
//   commit             out  commit_packet_t registered {id, valid, phys_addr, data}
//   grant_unit         out  3               unit that produced commit
module writeback_commit_arbiter
  import cva5_types::*;
#(
  parameter int NUM_UNITS     = 4,
  parameter int PRIORITY_UNIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  wb_packet_t           wb_packet    [NUM_UNITS],
  input  phys_addr_t           wb_phys_addr [NUM_UNITS],
  output logic [NUM_UNITS-1:0] wb_ack,
  input  logic                 writeback_supress,
  output commit_packet_t       commit,
  output logic [2:0]           grant_unit
);

  localparam int IDX_W        = $clog2(NUM_UNITS);
  localparam bit HAS_PRIORITY = (PRIORITY_UNIT >= 0);
  localparam int PRI_IDX      = HAS_PRIORITY ? PRIORITY_UNIT : 0;

  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] rr_grant;
  logic [IDX_W-1:0]     rr_idx;
  logic                 rr_valid;

  logic                 grant_en;
  logic                 pri_hit;
  logic                 grant_any;
  logic [IDX_W-1:0]     sel_idx;

  logic [IDX_W-1:0]     rr_ptr_d, rr_ptr_q;
  commit_packet_t       commit_d, commit_q;
  logic [2:0]           grant_unit_d, grant_unit_q;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      req[i] = wb_packet[i].valid;
    end
  end

  rr_priority_select #(
    .NUM_REQ (NUM_UNITS),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req         (req),
    .ptr         (rr_ptr_q),
    .grant       (rr_grant),
    .grant_idx   (rr_idx),
    .grant_valid (rr_valid)
  );

  // Reset is folded into the grant enable so no unit is told to drop a
  // result while the commit register is being held in reset.
  assign grant_en = rst & ~writeback_supress;
  assign pri_hit  = HAS_PRIORITY && req[PRI_IDX];

  // Grant selection: the priority unit overrides the round-robin winner and
  // does not move the pointer; only round-robin grants advance it.
  always_comb begin
    wb_ack    = '0;
    sel_idx   = '0;
    grant_any = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    if (grant_en) begin
      if (pri_hit) begin
        wb_ack[PRI_IDX] = 1'b1;
        sel_idx         = IDX_W'(PRI_IDX);
        grant_any       = 1'b1;
      end else if (rr_valid) begin
        wb_ack    = rr_grant;
        sel_idx   = rr_idx;
        grant_any = 1'b1;
        rr_ptr_d  = IDX_W'(wrap_inc(int'(rr_idx), NUM_UNITS));
      end
    end
  end

  // Commit payload and trace index hold their last value on idle cycles;
  // only valid drops, which keeps the wide data bus from toggling.
  always_comb begin
    commit_d       = commit_q;
    commit_d.valid = 1'b0;
    grant_unit_d   = grant_unit_q;
    if (grant_any) begin
      commit_d.id        = wb_packet[sel_idx].id;
      commit_d.valid     = 1'b1;
      commit_d.phys_addr = wb_phys_addr[sel_idx];
      commit_d.data      = wb_packet[sel_idx].data;
      grant_unit_d       = 3'(sel_idx);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q     <= '0;
      commit_q     <= '0;
      grant_unit_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      commit_q     <= commit_d;
      grant_unit_q <= grant_unit_d;
    end
  end

  assign commit     = commit_q;
  assign grant_unit = grant_unit_q;

endmodule
